// File: rtl/pc_sel_ctrl.sv
// Next-PC select sequencer for the IF stage, with a post-redirect masking window (optional stats: PC_SEL_STATS_EN).
// Latency: o_pc_sel and the flushes are combinational from state and inputs; o_busy and the counters are registered.
// Backpressure: i_stall selects hold (3) unless a redirect is taken; a stall freezes the masking window countdown.
module pc_sel_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_stall,
  input  logic                 i_pred_taken,
  input  logic                 i_ex_br_valid,
  input  logic                 i_ex_mispredict,
  output logic [1:0]           o_pc_sel,
  output logic                 o_flush_ifid,
  output logic                 o_flush_idex,
  output logic                 o_busy,
  output logic [CNT_WIDTH-1:0] o_br_cnt,
  output logic [CNT_WIDTH-1:0] o_mispred_cnt
);

  localparam logic [1:0] SEL_SEQ  = 2'd0;
  localparam logic [1:0] SEL_PRED = 2'd1;
  localparam logic [1:0] SEL_CORR = 2'd2;
  localparam logic [1:0] SEL_HOLD = 2'd3;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] mask_q, mask_d;
  logic       redirect;
  logic [1:0] sel;

  // Only a qualified mispredict seen in RUN redirects; wrong-path residue in FLUSH is ignored.
  always_comb begin
    redirect = (state_q == RUN) & i_ex_br_valid & i_ex_mispredict;
  end

  // Next-state and select: redirect beats stall (the stalled instruction is on the wrong path).
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    sel     = SEL_SEQ;
    if (redirect) begin
      sel = SEL_CORR;
    end else if (i_stall) begin
      sel = SEL_HOLD;
    end else if (i_pred_taken) begin
      sel = SEL_PRED;
    end
    case (state_q)
      RUN: begin
        if (redirect && (FLUSH_CYCLES > 0)) begin
          state_d = FLUSH;
          mask_d  = 4'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        // A frozen pipeline does not drain residue, so count only advancing cycles.
        if (!i_stall) begin
          mask_d = mask_q - 4'd1;
          if (mask_q == 4'd1) begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = RUN;
        mask_d  = 4'd0;
      end
    endcase
  end

  // State and mask counter; reset aborts any window in progress.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RUN;
      mask_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  // Outputs are held quiet while reset is asserted, whatever the inputs do.
  always_comb begin
    o_pc_sel     = i_rst_n ? sel : SEL_SEQ;
    o_flush_ifid = i_rst_n & redirect;
    o_flush_idex = i_rst_n & redirect;
    o_busy       = (state_q == FLUSH);
  end

`ifdef PC_SEL_STATS_EN
  logic [CNT_WIDTH-1:0] br_cnt_q;
  logic [CNT_WIDTH-1:0] mis_cnt_q;

  // Saturating event counters; resolutions masked in FLUSH are not counted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if ((state_q == RUN) && i_ex_br_valid && (br_cnt_q != '1)) begin
        br_cnt_q <= br_cnt_q + CNT_WIDTH'(1);
      end
      if (redirect && (mis_cnt_q != '1)) begin
        mis_cnt_q <= mis_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign o_br_cnt      = br_cnt_q;
  assign o_mispred_cnt = mis_cnt_q;
`else
  assign o_br_cnt      = '0;
  assign o_mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_sel_ctrl.sv
// Directed bench for pc_sel_ctrl: default instance (FLUSH_CYCLES=2) and a FLUSH_CYCLES=0, CNT_WIDTH=4 instance.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Counter expectations depend on whether PC_SEL_STATS_EN is defined for the build.
module tb_pc_sel_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_pred_taken = 1'b0;
  logic        i_ex_br_valid = 1'b0;
  logic        i_ex_mispredict = 1'b0;

  logic [1:0]  a_pc_sel;
  logic        a_flush_ifid, a_flush_idex, a_busy;
  logic [15:0] a_br_cnt, a_mispred_cnt;

  logic [1:0]  z_pc_sel;
  logic        z_flush_ifid, z_flush_idex, z_busy;
  logic [3:0]  z_br_cnt, z_mispred_cnt;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  pc_sel_ctrl #(.FLUSH_CYCLES(2), .CNT_WIDTH(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_pred_taken(i_pred_taken),
    .i_ex_br_valid(i_ex_br_valid), .i_ex_mispredict(i_ex_mispredict),
    .o_pc_sel(a_pc_sel), .o_flush_ifid(a_flush_ifid), .o_flush_idex(a_flush_idex),
    .o_busy(a_busy), .o_br_cnt(a_br_cnt), .o_mispred_cnt(a_mispred_cnt)
  );

  pc_sel_ctrl #(.FLUSH_CYCLES(0), .CNT_WIDTH(4)) dut0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_pred_taken(i_pred_taken),
    .i_ex_br_valid(i_ex_br_valid), .i_ex_mispredict(i_ex_mispredict),
    .o_pc_sel(z_pc_sel), .o_flush_ifid(z_flush_ifid), .o_flush_idex(z_flush_idex),
    .o_busy(z_busy), .o_br_cnt(z_br_cnt), .o_mispred_cnt(z_mispred_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the default instance's select, flushes and busy together.
  task automatic chk_a(input string tag, input logic [1:0] sel, input logic fl, input logic busy);
    chk({tag, ".sel"}, 32'(a_pc_sel), 32'(sel));
    chk({tag, ".flush_ifid"}, 32'(a_flush_ifid), 32'(fl));
    chk({tag, ".flush_idex"}, 32'(a_flush_idex), 32'(fl));
    chk({tag, ".busy"}, 32'(a_busy), 32'(busy));
  endtask

  task automatic drive(input logic st, input logic pr, input logic bv, input logic mp);
    i_stall = st; i_pred_taken = pr; i_ex_br_valid = bv; i_ex_mispredict = mp;
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    // Reset asserted with every input active: outputs must stay quiet.
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    #12;
    chk_a("reset", 2'd0, 1'b0, 1'b0);
    chk("reset.br_cnt", 32'(a_br_cnt), 32'd0);
    chk("reset.mis_cnt", 32'(a_mispred_cnt), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    i_rst_n = 1'b1;

    // Idle after reset release.
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk_a("idle", 2'd0, 1'b0, 1'b0);
      chk("idle.br_cnt", 32'(a_br_cnt), 32'd0);
      next_cycle();
    end

    // Source selection.
    drive(1'b0, 1'b1, 1'b0, 1'b0); @(negedge i_clk); chk_a("pred", 2'd1, 1'b0, 1'b0); next_cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b0); @(negedge i_clk); chk_a("pred_stall", 2'd3, 1'b0, 1'b0); next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0); @(negedge i_clk); chk_a("seq", 2'd0, 1'b0, 1'b0); next_cycle();

    // Mispredict without valid is ignored.
    drive(1'b0, 1'b0, 1'b0, 1'b1); @(negedge i_clk); chk_a("mis_novld", 2'd0, 1'b0, 1'b0); next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0); @(negedge i_clk); chk_a("mis_novld+1", 2'd0, 1'b0, 1'b0); next_cycle();

    // Correct prediction resolved: no redirect.
    drive(1'b0, 1'b0, 1'b1, 1'b0); @(negedge i_clk); chk_a("br_ok", 2'd0, 1'b0, 1'b0); next_cycle();

    // Redirect with simultaneous stall: redirect wins.
    drive(1'b1, 1'b0, 1'b1, 1'b1); @(negedge i_clk); chk_a("redir", 2'd2, 1'b1, 1'b0); next_cycle();
    // Second mispredict pulse inside the window is masked.
    drive(1'b0, 1'b0, 1'b1, 1'b1); @(negedge i_clk); chk_a("redir+1", 2'd0, 1'b0, 1'b1); next_cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0); @(negedge i_clk); chk_a("redir+2", 2'd1, 1'b0, 1'b1); next_cycle();
    // Window closed; the first RUN cycle accepts a resolution (starts the stall-extension case).
    drive(1'b0, 1'b0, 1'b1, 1'b1); @(negedge i_clk); chk_a("redir+3", 2'd2, 1'b1, 1'b0); next_cycle();

    // Stall for three cycles freezes the countdown; masked pulses meanwhile.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1); @(negedge i_clk); chk_a("ext_stall", 2'd3, 1'b0, 1'b1); next_cycle();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0); @(negedge i_clk); chk_a("ext_drain", 2'd0, 1'b0, 1'b1); next_cycle();
    end
    @(negedge i_clk); chk_a("ext_done", 2'd0, 1'b0, 1'b0); next_cycle();

    // FLUSH_CYCLES=0 instance: back-to-back mispredicts both redirect.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      @(negedge i_clk);
      chk("z.sel", 32'(z_pc_sel), 32'd2);
      chk("z.flush_ifid", 32'(z_flush_ifid), 32'd1);
      chk("z.flush_idex", 32'(z_flush_idex), 32'd1);
      chk("z.busy", 32'(z_busy), 32'd0);
      next_cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
    chk("z.busy_after", 32'(z_busy), 32'd0);
    // Default instance entered a window on the first of those; reset aborts it at once.
    chk("a.busy_pre_rst", 32'(a_busy), 32'd1);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("a.busy_rst", 32'(a_busy), 32'd0);
    next_cycle();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk_a("after_abort", 2'd0, 1'b0, 1'b0);
    chk("a.br_cnt_clr", 32'(a_br_cnt), 32'd0);
    chk("z.br_cnt_clr", 32'(z_br_cnt), 32'd0);
    next_cycle();

    // Statistics: 20 correctly predicted branches, then one mispredict.
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (20) @(posedge i_clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
`ifdef PC_SEL_STATS_EN
    chk("z.br_cnt_sat", 32'(z_br_cnt), 32'd15);
    chk("a.br_cnt_20", 32'(a_br_cnt), 32'd20);
`else
    chk("z.br_cnt_sat", 32'(z_br_cnt), 32'd0);
    chk("a.br_cnt_20", 32'(a_br_cnt), 32'd0);
`endif
    chk("z.mis_cnt_0", 32'(z_mispred_cnt), 32'd0);
    chk("a.mis_cnt_0", 32'(a_mispred_cnt), 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
`ifdef PC_SEL_STATS_EN
    chk("z.mis_cnt_1", 32'(z_mispred_cnt), 32'd1);
    chk("z.br_cnt_hold", 32'(z_br_cnt), 32'd15);
    chk("a.mis_cnt_1", 32'(a_mispred_cnt), 32'd1);
    chk("a.br_cnt_21", 32'(a_br_cnt), 32'd21);
`else
    chk("z.mis_cnt_1", 32'(z_mispred_cnt), 32'd0);
    chk("z.br_cnt_hold", 32'(z_br_cnt), 32'd0);
    chk("a.mis_cnt_1", 32'(a_mispred_cnt), 32'd0);
    chk("a.br_cnt_21", 32'(a_br_cnt), 32'd0);
`endif
    chk("a.busy_stats", 32'(a_busy), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sel_ctrl.md
Name: pc_sel_ctrl

Overview:
- Sequencing controller for the 4:1 next-PC select mux in the IF stage of the RV32I pipeline.
- Arbitrates four PC sources each cycle:
  - sequential PC+4
  - predictor target
  - EX-resolved correction target
  - hold current PC
- Drives IF/ID and ID/EX flush on mispredict.
- Runs a post-redirect masking window so wrong-path residue cannot retrigger a redirect. Optionally counts branch and mispredict events.

Parameters:
- FLUSH_CYCLES, 2, cycles after a redirect during which EX branch resolution is ignored; legal range 0..15.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_stall  input  1  load-use or memory hazard; hold PC
- i_pred_taken  input  1  IF-stage predictor: BTB hit and predicted taken
- i_ex_br_valid  input  1  branch/jump resolved in EX this cycle
- i_ex_mispredict  input  1  resolved outcome or target differs from prediction; qualified by i_ex_br_valid
- o_pc_sel  output  2  next-PC mux select: 0=PC+4, 1=predicted target, 2=EX correction target, 3=hold
- o_flush_ifid  output  1  flush IF/ID register
- o_flush_idex  output  1  flush ID/EX register
- o_busy  output  1  masking window active
- o_br_cnt  output  CNT_WIDTH  resolved branches accepted
- o_mispred_cnt  output  CNT_WIDTH  mispredicts accepted

Behaviour:
- Clock and reset:
  - Single clock domain on i_clk.
  - Reset is asynchronous and active-low on i_rst_n.
  - Reset forces state=RUN, mask counter=0, o_br_cnt=0, o_mispred_cnt=0.
  - While reset is asserted: o_pc_sel=0, o_flush_ifid=0, o_flush_idex=0, o_busy=0.
- o_pc_sel, o_flush_ifid and o_flush_idex are combinational from state and inputs (zero latency), so the PC register captures the correct source on the same edge.
- Define redirect = (state==RUN) & i_ex_br_valid & i_ex_mispredict.
- Select priority:
  - redirect -> 2
  - else i_stall -> 3
  - else i_pred_taken -> 1
  - else 0
- Redirect outranks stall: a simultaneous i_stall is dropped because the stalled instruction is on the wrong path.
- Flushes: o_flush_ifid = o_flush_idex = redirect. They are never asserted in FLUSH state.
- State RUN:
  - On redirect with FLUSH_CYCLES>0: go to FLUSH and load mask counter = FLUSH_CYCLES.
  - On redirect with FLUSH_CYCLES==0: stay in RUN.
- State FLUSH:
  - o_busy=1.
  - i_ex_br_valid and i_ex_mispredict are ignored: no redirect, no flush, no statistics update.
  - o_pc_sel follows stall > pred > seq.
  - Counter decrements once per cycle only when i_stall=0, because a frozen pipeline does not advance the residue.
  - Transition to RUN on the edge where counter goes 1->0. The first cycle back in RUN accepts resolutions.
- i_ex_mispredict without i_ex_br_valid is ignored in all states.
- Reset asserted mid-FLUSH aborts the window immediately; state returns to RUN.

Optional Feature:
- Macro: PC_SEL_STATS_EN.
- Defined:
  - o_br_cnt increments on every cycle with state==RUN & i_ex_br_valid.
  - o_mispred_cnt increments on every redirect.
  - Both saturate at all-ones and never wrap.
  - Masked resolutions in FLUSH are not counted.
- Undefined: no counter registers exist; o_br_cnt and o_mispred_cnt are tied to 0.

Test Plan:
- Reset and idle: release i_rst_n with all inputs 0 -> o_pc_sel=0, flushes=0, o_busy=0, counters=0 on every cycle.
- Source selection: i_pred_taken=1 -> o_pc_sel=1; add i_stall=1 -> o_pc_sel=3; drop both -> o_pc_sel=0.
- Redirect and masking window:
  - Stimulus: in RUN assert i_ex_br_valid=1, i_ex_mispredict=1 with i_stall=1 (FLUSH_CYCLES=2).
  - Same cycle: o_pc_sel=2, o_flush_ifid=1, o_flush_idex=1.
  - Next 2 cycles: o_busy=1.
  - A second mispredict pulse in cycle +1 gives o_pc_sel!=2 and no flush.
  - Cycle +3: o_busy=0.
- Stall extends the window: redirect, then i_stall=1 for 3 cycles -> o_busy stays 1 for 3+2=5 cycles, with o_pc_sel=3 while stalled.
- FLUSH_CYCLES=0 build: back-to-back mispredicts on consecutive cycles -> o_pc_sel=2 and both flushes on both cycles; o_busy never asserts.
- PC_SEL_STATS_EN with CNT_WIDTH=4:
  - 20 accepted correctly-predicted branches -> o_br_cnt=15 (saturated), o_mispred_cnt=0.
  - 1 mispredict -> o_mispred_cnt=1; o_br_cnt remains 15.
